// File: rtl/control_cmd_router.sv
// rtl/control_cmd_router.sv - opcode decoder and byte router for control_cmd_* subcommand engines
//
// The first received byte of a command is matched against OPCODES; the lowest
// matching index becomes the selected subcommand. Every later byte goes out on
// the shared sub_data bus with a one-cycle sub_enable bit for that subcommand.
// The router returns to opcode hunting when the selected subcommand pulses done.
//
// Optional feature macro: CONTROL_CMD_ROUTER_TIMEOUT_EN
//   When it is defined, an idle watchdog aborts a ROUTE that sits silent for
//   TIMEOUT_CYCLES clocks. When it is undefined, sub_abort and err_timeout are
//   tied to 0.
//
// Ports:
//   clk          in   system clock, single domain
//   reset        in   synchronous, active-high; dominates all other inputs
//   data_in      in   [7:0] received byte, valid with data_valid
//   data_valid   in   one-cycle strobe per byte
//   sub_done     in   [NUM_CMDS-1:0] per-subcommand done pulse
//   sub_data     out  [7:0] registered byte to the subcommands (holds between bytes)
//   sub_enable   out  [NUM_CMDS-1:0] one-hot enable pulse for the selected subcommand
//   sub_abort    out  [NUM_CMDS-1:0] one-hot abort pulse on timeout
//   active_cmd   out  [AW-1:0] selected subcommand index, valid while busy
//   busy         out  1 while routing payload (ROUTE)
//   err_unknown  out  one-cycle pulse: opcode matched no entry
//   err_timeout  out  one-cycle pulse: watchdog abort

module control_cmd_router #(
    parameter int         NUM_CMDS                 = 4,
    parameter logic [7:0] OPCODES [NUM_CMDS]       = '{8'h52, 8'h57, 8'h43, 8'h42},
    parameter int         TIMEOUT_CYCLES           = 65536,
    localparam int        AW                       = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          data_in,
    input  logic                data_valid,
    input  logic [NUM_CMDS-1:0] sub_done,
    output logic [7:0]          sub_data,
    output logic [NUM_CMDS-1:0] sub_enable,
    output logic [NUM_CMDS-1:0] sub_abort,
    output logic [AW-1:0]       active_cmd,
    output logic                busy,
    output logic                err_unknown,
    output logic                err_timeout
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ROUTE = 1'b1;

    // The watchdog counter is 17 bits wide, so the limit must fit in it.
    generate
        if (NUM_CMDS < 1 || NUM_CMDS > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 131072) begin : g_param_check
            $error("control_cmd_router: parameter out of range");
        end
    endgenerate

    logic [0:0]          state;
    logic                hit;
    logic [AW-1:0]       hit_idx;
    logic                done_sel;
    logic [NUM_CMDS-1:0] sel_onehot;

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_CMDS - 1; i >= 0; i--) begin
            if (data_in == OPCODES[i]) begin
                hit     = 1'b1;
                hit_idx = AW'(i);
            end
        end
    end

    // Only the selected engine's done is honoured; the others are ignored.
    assign done_sel   = sub_done[active_cmd];
    assign sel_onehot = NUM_CMDS'(1) << active_cmd;
    assign busy       = (state == ST_ROUTE);

`ifdef CONTROL_CMD_ROUTER_TIMEOUT_EN
    localparam logic [16:0] TIMEOUT_LAST = 17'(TIMEOUT_CYCLES - 1);

    logic [16:0] to_cnt;
    logic        timeout_hit;

    // A byte arriving in the same cycle restarts the count, so it can never expire.
    assign timeout_hit = (state == ST_ROUTE) && !data_valid && (to_cnt == TIMEOUT_LAST);

    // Held at 0 outside ROUTE, which also gives the clear on entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (state != ST_ROUTE || data_valid) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 17'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            sub_data    <= '0;
            sub_enable  <= '0;
            active_cmd  <= '0;
            err_unknown <= 1'b0;
`ifdef CONTROL_CMD_ROUTER_TIMEOUT_EN
            sub_abort   <= '0;
            err_timeout <= 1'b0;
`endif
        end else begin
            sub_enable  <= '0;
            err_unknown <= 1'b0;
`ifdef CONTROL_CMD_ROUTER_TIMEOUT_EN
            sub_abort   <= '0;
            err_timeout <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    // The opcode byte selects an engine but is never forwarded.
                    if (data_valid) begin
                        if (hit) begin
                            active_cmd <= hit_idx;
                            state      <= ST_ROUTE;
                        end else begin
                            err_unknown <= 1'b1;
                        end
                    end
                end
                ST_ROUTE: begin
                    // A byte arriving together with done still belongs to the
                    // current command; the engine owns its own framing.
                    if (data_valid) begin
                        sub_data   <= data_in;
                        sub_enable <= sel_onehot;
                    end
                    if (done_sel) begin
                        state <= ST_IDLE;
                    end
`ifdef CONTROL_CMD_ROUTER_TIMEOUT_EN
                    else if (timeout_hit) begin
                        sub_abort   <= sel_onehot;
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end
`endif
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifndef CONTROL_CMD_ROUTER_TIMEOUT_EN
    assign sub_abort   = '0;
    assign err_timeout = 1'b0;
`endif

endmodule
